// File: rtl/imem_load_ctrl.sv
// Instruction-memory loader/arbiter: assembles a byte stream into words, then hands the port to fetch.
// Optional `IMEM_CHECKSUM_EN adds the load_csum output (sum of written words).
module imem_load_ctrl #(
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned AW      = 5,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_start,
   input  logic [AW:0]   load_len,
   input  logic          run_start,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   input  logic [31:0]   core_pc,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [31:0]   mem_wdata,
   output logic          cpu_hold,
   output logic          load_done,
   output logic          load_err
`ifdef IMEM_CHECKSUM_EN
   ,
   output logic [31:0]   load_csum
`endif
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StLoad  = 2'd1;
   localparam logic [1:0] StWrite = 2'd2;
   localparam logic [1:0] StRun   = 2'd3;

   localparam int unsigned IW      = $clog2(TIMEOUT + 1);
   localparam logic [AW:0] DepthW  = (AW + 1)'(DEPTH);
   localparam logic [IW-1:0] IdleMax = IW'(TIMEOUT - 1);

   logic [1:0]    state_q, state_d;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [1:0]    byte_cnt_q, byte_cnt_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [31:0]   word_q, word_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [AW:0]   addr_inc;
   logic          accept;
`ifdef IMEM_CHECKSUM_EN
   logic [31:0]   csum_q, csum_d;
`endif

   assign accept   = (state_q == StLoad) && byte_valid;
   assign addr_inc = {1'b0, addr_q} + {{AW{1'b0}}, 1'b1};

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      addr_d     = addr_q;
      byte_cnt_d = byte_cnt_q;
      idle_d     = idle_q;
      word_d     = word_q;
      done_d     = 1'b0;
      err_d      = err_q;
`ifdef IMEM_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      case (state_q)
         StIdle, StRun: begin
            if (load_start) begin
               len_d      = load_len;
               addr_d     = '0;
               byte_cnt_d = '0;
               idle_d     = '0;
               word_d     = '0;
               err_d      = 1'b0;
`ifdef IMEM_CHECKSUM_EN
               csum_d     = '0;
`endif
               // Degenerate lengths are resolved at the start edge, never entering LOAD.
               if (load_len == '0) begin
                  state_d = StRun;
                  done_d  = 1'b1;
               end else if (load_len > DepthW) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StLoad;
               end
            end else if (run_start && (state_q == StIdle)) begin
               state_d = StRun;
            end
         end
         StLoad: begin
            if (accept) begin
               unique case (byte_cnt_q)
                  2'd0: word_d[7:0]   = byte_data;
                  2'd1: word_d[15:8]  = byte_data;
                  2'd2: word_d[23:16] = byte_data;
                  2'd3: word_d[31:24] = byte_data;
                  default: ;
               endcase
               byte_cnt_d = byte_cnt_q + 2'd1;
               idle_d     = '0;
               if (byte_cnt_q == 2'd3) state_d = StWrite;
            end else if (byte_cnt_q != 2'd0) begin
               if (idle_q == IdleMax) begin
                  err_d      = 1'b1;
                  state_d    = StIdle;
                  byte_cnt_d = '0;
                  idle_d     = '0;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
         end
         StWrite: begin
            addr_d     = addr_inc[AW-1:0];
            byte_cnt_d = '0;
`ifdef IMEM_CHECKSUM_EN
            csum_d     = csum_q + word_q;
`endif
            if (addr_inc == len_q) begin
               state_d = StRun;
               done_d  = 1'b1;
            end else begin
               state_d = StLoad;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         len_q      <= '0;
         addr_q     <= '0;
         byte_cnt_q <= '0;
         idle_q     <= '0;
         word_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         addr_q     <= addr_d;
         byte_cnt_q <= byte_cnt_d;
         idle_q     <= idle_d;
         word_q     <= word_d;
         done_q     <= done_d;
         err_q      <= err_d;
`ifdef IMEM_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   // Fetch address path is purely combinational so the core sees zero added latency.
   assign mem_addr   = (state_q == StRun) ? core_pc[AW+1:2] : addr_q;
   assign mem_we     = (state_q == StWrite);
   assign mem_wdata  = word_q;
   assign byte_ready = (state_q == StLoad);
   assign cpu_hold   = (state_q != StRun);
   assign load_done  = done_q;
   assign load_err   = err_q;
`ifdef IMEM_CHECKSUM_EN
   assign load_csum  = csum_q;
`endif

   logic unused_pc;
   assign unused_pc = ^{core_pc[31:AW+2], core_pc[1:0]};

endmodule
